// File: rtl/dcache_pkg.sv
// Shared definitions for the data cache: word/block geometry, controller
// state encoding and helpers that pick or merge a big-endian word in a block.
package dcache_pkg;

    localparam int WORD_SIZE  = 32;
    localparam int BYTE_SIZE  = 8;
    localparam int BLOCK_SIZE = 1024;

    typedef enum logic [2:0] {
        IDLE,
        WB,
        WB_GAP,
        FILL,
        FILL_GAP,
        DRAIN,
        DONE
    } state_t;

    // Byte 0 of a block sits in its most significant bits.
    function automatic logic [WORD_SIZE-1:0] get_word(input logic [BLOCK_SIZE-1:0] blk,
                                                      input int off);
        return blk[BLOCK_SIZE-1-BYTE_SIZE*off -: WORD_SIZE];
    endfunction

    function automatic logic [BLOCK_SIZE-1:0] put_word(input logic [BLOCK_SIZE-1:0] blk,
                                                       input int off,
                                                       input logic [WORD_SIZE-1:0] word);
        logic [BLOCK_SIZE-1:0] res;
        res = blk;
        res[BLOCK_SIZE-1-BYTE_SIZE*off -: WORD_SIZE] = word;
        return res;
    endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/dirty/data storage for the direct-mapped cache.
// One combinational read port and one synchronous full-entry write port.
module dcache_array
    import dcache_pkg::*;
#(
    parameter int NUM_LINES = 16,
    parameter int IDX_W     = 4,
    parameter int TAG_W     = 21
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic                  rd_valid,
    output logic                  rd_dirty,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [BLOCK_SIZE-1:0] rd_data,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic                  wr_valid,
    input  logic                  wr_dirty,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [BLOCK_SIZE-1:0] wr_data
);

    logic [NUM_LINES-1:0]  valid;
    logic [NUM_LINES-1:0]  dirty;
    logic [TAG_W-1:0]      tags  [NUM_LINES];
    logic [BLOCK_SIZE-1:0] lines [NUM_LINES];

    assign rd_valid = valid[rd_idx];
    assign rd_dirty = dirty[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign rd_data  = lines[rd_idx];

    // Status bits are cleared by reset so every line starts invalid and clean.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            dirty <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= wr_valid;
            dirty[wr_idx] <= wr_dirty;
        end
    end

    // Tag and data contents only matter once valid is set, so they are not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tags[wr_idx]  <= wr_tag;
            lines[wr_idx] <= wr_data;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back, write-allocate data cache controller.
// Optional statistics counters (hit/miss/write-back) are built when the
// macro DCACHE_STATS_EN is defined.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int NUM_LINES   = 16,
    parameter int MEM_LATENCY = 2,
    parameter int OFF_BITS    = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [WORD_SIZE-1:0]  cpu_addr,
    input  logic [WORD_SIZE-1:0]  cpu_wdata,
    output logic                  cpu_ready,
    output logic [WORD_SIZE-1:0]  cpu_rdata,
    input  logic                  halt,
    output logic [WORD_SIZE-1:0]  mem_in,
    output logic                  mem_readable,
    output logic                  mem_writable,
    output logic [BLOCK_SIZE-1:0] mem_write,
    input  logic [BLOCK_SIZE-1:0] mem_out1,
    input  logic [BLOCK_SIZE-1:0] mem_out2,
    output logic                  mem_flush
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]           hit_cnt,
    output logic [31:0]           miss_cnt,
    output logic [31:0]           wb_cnt
`endif
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = WORD_SIZE - OFF_BITS - IDX_W;
    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_LINES - 1);

    state_t                state;
    logic [IDX_W-1:0]      drain_idx;
    logic [CNT_W-1:0]      fill_cnt;
    logic                  draining;

    logic [OFF_BITS-1:0]   cpu_off;
    logic [IDX_W-1:0]      cpu_idx;
    logic [TAG_W-1:0]      cpu_tag;

    logic [IDX_W-1:0]      rd_idx;
    logic                  rd_valid;
    logic                  rd_dirty;
    logic [TAG_W-1:0]      rd_tag;
    logic [BLOCK_SIZE-1:0] rd_data;
    logic                  wr_en;
    logic                  wr_valid;
    logic                  wr_dirty;
    logic [TAG_W-1:0]      wr_tag;
    logic [BLOCK_SIZE-1:0] wr_data;

    logic                  service;
    logic                  hit;
    logic                  wb_start;
    logic                  fill_done;
    logic                  unused_mem_out2;

    assign cpu_off = cpu_addr[OFF_BITS-1:0];
    assign cpu_idx = cpu_addr[OFF_BITS +: IDX_W];
    assign cpu_tag = cpu_addr[WORD_SIZE-1 -: TAG_W];

    // The next block is never needed by a direct-mapped single-line fill.
    assign unused_mem_out2 = ^mem_out2;

    // During halt the array is scanned by the drain index instead of the CPU address.
    assign rd_idx    = draining ? drain_idx : cpu_idx;
    assign hit       = rd_valid && (rd_tag == cpu_tag);
    assign service   = (state == IDLE) && cpu_req && !cpu_ready;
    assign fill_done = (state == FILL) && (fill_cnt == CNT_LAST);
    assign wb_start  = ((service && !hit) || (state == DRAIN)) && rd_valid && rd_dirty;

    dcache_array #(
        .NUM_LINES (NUM_LINES),
        .IDX_W     (IDX_W),
        .TAG_W     (TAG_W)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (rd_idx),
        .rd_valid (rd_valid),
        .rd_dirty (rd_dirty),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (wr_en),
        .wr_idx   (rd_idx),
        .wr_valid (wr_valid),
        .wr_dirty (wr_dirty),
        .wr_tag   (wr_tag),
        .wr_data  (wr_data)
    );

    // Array updates: store-hit merge, line install at end of fill, dirty clear after a drain write-back.
    always_comb begin
        wr_en    = 1'b0;
        wr_valid = rd_valid;
        wr_dirty = rd_dirty;
        wr_tag   = rd_tag;
        wr_data  = rd_data;
        if (!rst) begin
            if (service && hit && cpu_we) begin
                wr_en    = 1'b1;
                wr_dirty = 1'b1;
                wr_data  = put_word(rd_data, int'(cpu_off), cpu_wdata);
            end else if (fill_done) begin
                wr_en    = 1'b1;
                wr_valid = 1'b1;
                wr_dirty = 1'b0;
                wr_tag   = cpu_tag;
                wr_data  = mem_out1;
            end else if (state == WB_GAP && draining) begin
                wr_en    = 1'b1;
                wr_dirty = 1'b0;
            end
        end
    end

    // Controller FSM with registered CPU and memory-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            drain_idx    <= '0;
            fill_cnt     <= '0;
            draining     <= 1'b0;
            cpu_ready    <= 1'b0;
            cpu_rdata    <= '0;
            mem_in       <= '0;
            mem_readable <= 1'b0;
            mem_writable <= 1'b0;
            mem_write    <= '0;
            mem_flush    <= 1'b0;
        end else begin
            cpu_ready <= 1'b0;
            case (state)
                IDLE: begin
                    if (service) begin
                        if (hit) begin
                            cpu_ready <= 1'b1;
                            if (!cpu_we) begin
                                cpu_rdata <= get_word(rd_data, int'(cpu_off));
                            end
                        end else if (wb_start) begin
                            state        <= WB;
                            mem_in       <= {rd_tag, cpu_idx, {OFF_BITS{1'b0}}};
                            mem_write    <= rd_data;
                            mem_writable <= 1'b1;
                        end else begin
                            state        <= FILL;
                            mem_in       <= {cpu_tag, cpu_idx, {OFF_BITS{1'b0}}};
                            mem_readable <= 1'b1;
                            fill_cnt     <= '0;
                        end
                    end else if (halt) begin
                        state     <= DRAIN;
                        draining  <= 1'b1;
                        drain_idx <= '0;
                    end
                end
                WB: begin
                    state        <= WB_GAP;
                    mem_writable <= 1'b0;
                end
                WB_GAP: begin
                    if (draining) begin
                        if (drain_idx == IDX_LAST) begin
                            state     <= DONE;
                            mem_flush <= 1'b1;
                        end else begin
                            state     <= DRAIN;
                            drain_idx <= drain_idx + 1'b1;
                        end
                    end else begin
                        state        <= FILL;
                        mem_in       <= {cpu_tag, cpu_idx, {OFF_BITS{1'b0}}};
                        mem_readable <= 1'b1;
                        fill_cnt     <= '0;
                    end
                end
                FILL: begin
                    if (fill_done) begin
                        state        <= FILL_GAP;
                        mem_readable <= 1'b0;
                    end else begin
                        fill_cnt <= fill_cnt + 1'b1;
                    end
                end
                FILL_GAP: begin
                    state <= IDLE;
                end
                DRAIN: begin
                    if (wb_start) begin
                        state        <= WB;
                        mem_in       <= {rd_tag, drain_idx, {OFF_BITS{1'b0}}};
                        mem_write    <= rd_data;
                        mem_writable <= 1'b1;
                    end else if (drain_idx == IDX_LAST) begin
                        state     <= DONE;
                        mem_flush <= 1'b1;
                    end else begin
                        drain_idx <= drain_idx + 1'b1;
                    end
                end
                DONE: begin
                    mem_flush <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    logic replay;

    // Saturating event counters; the access replayed after a fill is not a first-attempt hit.
    always_ff @(posedge clk) begin
        if (rst) begin
            replay   <= 1'b0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
            wb_cnt   <= '0;
        end else begin
            if (fill_done) begin
                replay <= 1'b1;
            end else if (service) begin
                replay <= 1'b0;
            end
            if (service && hit && !replay && hit_cnt != '1) begin
                hit_cnt <= hit_cnt + 1'b1;
            end
            if (service && !hit && miss_cnt != '1) begin
                miss_cnt <= miss_cnt + 1'b1;
            end
            if (wb_start && wb_cnt != '1) begin
                wb_cnt <= wb_cnt + 1'b1;
            end
        end
    end
`endif

endmodule
